// File: rtl/eth_sniffer_pkg.sv
// Shared constants and helpers for the address-match bank.
// Default widths, the entry record and the window-depth rule live here.
package eth_sniffer_pkg;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 48;
    localparam int DEF_NUM_ENTRIES = 4;

    typedef struct packed {
        logic                  en;
        logic [DEF_ADDR_W-1:0] addr;
    } entry_t;

    // One extra word beyond the address span so every byte alignment fits.
    function automatic int window_depth(input int addr_w, input int data_w);
        return (addr_w + data_w - 1) / data_w + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/addr_match_bank_if.sv
// Bundle of config, stream and match-status signals for addr_match_bank.
// The master side drives config and stream; the slave side is the bank.
interface addr_match_bank_if
    import eth_sniffer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) ();
    localparam int IDX_W = idx_width(NUM_ENTRIES);
    localparam int OFF_W = idx_width(DATA_W / 8);

    logic              clear;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic              cfg_en;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic [NUM_ENTRIES-1:0] match_vec;
    logic              match_any;
    logic              match_pulse;
    logic [IDX_W-1:0]  match_idx;
    logic [OFF_W-1:0]  match_offset;

    modport master (
        output clear, cfg_we, cfg_idx, cfg_addr, cfg_en, data_valid, data_in,
        input  data_out, data_out_valid, match_vec, match_any, match_pulse,
               match_idx, match_offset
    );

    modport slave (
        input  clear, cfg_we, cfg_idx, cfg_addr, cfg_en, data_valid, data_in,
        output data_out, data_out_valid, match_vec, match_any, match_pulse,
               match_idx, match_offset
    );
endinterface

// File: rtl/addr_match_entry.sv
// Combinational comparator: checks one entry against every byte alignment
// of the window and reports the lowest matching alignment.
module addr_match_entry
    import eth_sniffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int BYTES = DATA_W / 8,
    localparam int WIN_W = window_depth(ADDR_W, DATA_W) * DATA_W,
    localparam int OFF_W = idx_width(BYTES)
) (
    input  logic [WIN_W-1:0]  window,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [OFF_W-1:0]  k
);
    logic [BYTES-1:0] eq;

    genvar gi;
    for (gi = 0; gi < BYTES; gi++) begin : g_align
        assign eq[gi] = (window[WIN_W-1-8*gi -: ADDR_W] == addr);
    end

    always_comb begin
        hit = en && (|eq);
        k   = '0;
        // Scan downward so the lowest alignment is the one left standing.
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (eq[i]) k = OFF_W'(i);
        end
    end
endmodule

// File: rtl/addr_match_bank.sv
// Sliding byte-aligned address matcher over a word stream with a bank of
// programmable entries, sticky match flags and a delayed copy of the stream.
module addr_match_bank
    import eth_sniffer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    localparam int D      = window_depth(ADDR_W, DATA_W),
    localparam int WIN_W  = D * DATA_W,
    localparam int IDX_W  = idx_width(NUM_ENTRIES),
    localparam int OFF_W  = idx_width(DATA_W / 8),
    localparam int FILL_W = $clog2(D + 1)
) (
    input logic clk,
    input logic rst,
    addr_match_bank_if.slave bus
);
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
    } bank_entry_t;

    logic [DATA_W-1:0]      win_reg [D];
    logic [FILL_W-1:0]      fill_reg;
    logic [WIN_W-1:0]       window;
    logic                   window_full;
    logic [NUM_ENTRIES-1:0] hit_vec;
    logic [NUM_ENTRIES-1:0][OFF_W-1:0] hit_k;

    logic [NUM_ENTRIES-1:0] match_vec_reg, match_vec_next;
    logic                   match_pulse_reg, match_pulse_next;
    logic [IDX_W-1:0]       match_idx_reg, match_idx_next;
    logic [OFF_W-1:0]       match_offset_reg, match_offset_next;
    logic [DATA_W-1:0]      data_out_reg;
    logic                   data_out_valid_reg;

    assign window_full = (fill_reg == FILL_W'(D));

    genvar gi;
    // w[0] is the newest word and sits at the bottom of the flat window.
    for (gi = 0; gi < D; gi++) begin : g_win
        assign window[gi*DATA_W +: DATA_W] = win_reg[gi];
    end

    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        bank_entry_t entry_reg;
        logic        raw_hit;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (bus.cfg_we && (bus.cfg_idx == IDX_W'(gi))) begin
                entry_reg <= '{en: bus.cfg_en, addr: bus.cfg_addr};
            end
        end

        addr_match_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_entry (
            .window (window),
            .en     (entry_reg.en),
            .addr   (entry_reg.addr),
            .hit    (raw_hit),
            .k      (hit_k[gi])
        );

        assign hit_vec[gi] = raw_hit & window_full;
    end

    always_comb begin
        match_vec_next    = match_vec_reg | hit_vec;
        match_pulse_next  = (match_vec_reg == '0) && (hit_vec != '0);
        match_idx_next    = match_idx_reg;
        match_offset_next = match_offset_reg;
        // First match of the frame: lowest entry wins, then its lowest k.
        if (match_pulse_next) begin
            for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
                if (hit_vec[i]) begin
                    match_idx_next    = IDX_W'(i);
                    match_offset_next = hit_k[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) win_reg[i] <= '0;
            fill_reg           <= '0;
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
            match_vec_reg      <= '0;
            match_pulse_reg    <= 1'b0;
            match_idx_reg      <= '0;
            match_offset_reg   <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < D; i++) win_reg[i] <= '0;
            fill_reg           <= '0;
            data_out_valid_reg <= 1'b0;
            match_vec_reg      <= '0;
            match_pulse_reg    <= 1'b0;
            match_idx_reg      <= '0;
            match_offset_reg   <= '0;
        end else begin
            match_vec_reg      <= match_vec_next;
            match_pulse_reg    <= match_pulse_next;
            match_idx_reg      <= match_idx_next;
            match_offset_reg   <= match_offset_next;
            data_out_valid_reg <= 1'b0;
            if (bus.data_valid) begin
                win_reg[0] <= bus.data_in;
                for (int i = 1; i < D; i++) win_reg[i] <= win_reg[i-1];
                if (window_full) begin
                    data_out_reg       <= win_reg[D-1];
                    data_out_valid_reg <= 1'b1;
                end else begin
                    fill_reg <= fill_reg + 1'b1;
                end
            end
        end
    end

    assign bus.data_out       = data_out_reg;
    assign bus.data_out_valid = data_out_valid_reg;
    assign bus.match_vec      = match_vec_reg;
    assign bus.match_any      = |match_vec_reg;
    assign bus.match_pulse    = match_pulse_reg;
    assign bus.match_idx      = match_idx_reg;
    assign bus.match_offset   = match_offset_reg;
endmodule
